// File: rtl/ram_loader_if.sv
// Load-word stream and RAM write-bus signals for ram_loader.
// The master modport is the loader's view: it consumes the load stream and
// masters the RAM write channels. The slave modport is the environment's view.
interface ram_loader_if #(
  parameter int ADDR_WIDTH = 17
);
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [31:0]           in_data;
  logic                  in_last;

  logic [ADDR_WIDTH-1:0] ext_awaddr;
  logic                  ext_awvalid;
  logic                  ext_awready;
  logic [31:0]           ext_wdata;
  logic                  ext_wvalid;
  logic                  ext_wready;
  logic                  ext_bvalid;
  logic                  ext_bready;

  modport master (
    input  in_valid, in_addr, in_data, in_last,
    output in_ready,
    output ext_awaddr, ext_awvalid,
    input  ext_awready,
    output ext_wdata, ext_wvalid,
    input  ext_wready,
    input  ext_bvalid,
    output ext_bready
  );

  modport slave (
    output in_valid, in_addr, in_data, in_last,
    input  in_ready,
    input  ext_awaddr, ext_awvalid,
    output ext_awready,
    input  ext_wdata, ext_wvalid,
    output ext_wready,
    output ext_bvalid,
    input  ext_bready
  );
endinterface

// File: rtl/ram_loader.sv
// RAM image loader: takes one load word at a time, writes it to RAM over an
// AXI-style AW/W/B channel set, and after the last word holds the CPU in
// reset for RESET_HOLD cycles before releasing it. RUN is terminal.
module ram_loader #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 32,
  parameter int RESET_HOLD = 16
) (
  input  logic         clk,
  input  logic         resetn,
  ram_loader_if.master bus,
  output logic         cpu_resetn,
  output logic         busy,
  output logic         done,
  output logic         misalign_err,
  output logic [15:0]  word_count
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RESP,
    HOLD,
    RUN
  } state_t;

  // Hold counter starts one below RESET_HOLD so that RUN is reached exactly
  // RESET_HOLD edges after HOLD is entered.
  localparam logic [7:0] HOLD_LOAD = 8'(RESET_HOLD - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  cpu_resetn_q, cpu_resetn_d;
  logic                  misalign_q, misalign_d;
  logic [15:0]           count_q, count_d;
  logic [7:0]            hold_q, hold_d;

  logic                  aw_ok;
  logic                  w_ok;

  // A channel counts as complete once its valid has dropped or it is
  // handshaking this cycle, so AW and W may finish in either order.
  assign aw_ok = !awvalid_q || bus.ext_awready;
  assign w_ok  = !wvalid_q  || bus.ext_wready;

  // Next-state and registered-output decode for the load FSM.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    last_d       = last_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    misalign_d   = misalign_q;
    count_d      = count_q;
    hold_d       = hold_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          addr_d    = {bus.in_addr[ADDR_WIDTH-1:2], 2'b00};
          data_d    = bus.in_data;
          last_d    = bus.in_last;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          if (bus.in_addr[1:0] != 2'b00) begin
            misalign_d = 1'b1;
          end
          state_d   = WRITE;
        end
      end
      WRITE: begin
        if (awvalid_q && bus.ext_awready) begin
          awvalid_d = 1'b0;
        end
        if (wvalid_q && bus.ext_wready) begin
          wvalid_d = 1'b0;
        end
        if (aw_ok && w_ok) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.ext_bvalid) begin
          if (count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
          end
          if (last_q) begin
            hold_d  = HOLD_LOAD;
            state_d = HOLD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      HOLD: begin
        if (hold_q == 8'd0) begin
          state_d = RUN;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d       = (state_d == WRITE) || (state_d == RESP) || (state_d == HOLD);
    done_d       = (state_d == RUN);
    cpu_resetn_d = (state_d == RUN);
  end

  // State and output registers; reset abandons any in-flight write.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      last_q       <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cpu_resetn_q <= 1'b0;
      misalign_q   <= 1'b0;
      count_q      <= 16'd0;
      hold_q       <= 8'd0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      last_q       <= last_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cpu_resetn_q <= cpu_resetn_d;
      misalign_q   <= misalign_d;
      count_q      <= count_d;
      hold_q       <= hold_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.ext_bready  = (state_q == RESP);
  assign bus.ext_awaddr  = addr_q;
  assign bus.ext_awvalid = awvalid_q;
  assign bus.ext_wdata   = data_q;
  assign bus.ext_wvalid  = wvalid_q;

  assign cpu_resetn   = cpu_resetn_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign misalign_err = misalign_q;
  assign word_count   = count_q;

endmodule

// File: tb/tb_ram_loader.sv
// Testbench for ram_loader. Two instances share all inputs: one with the
// default 16-cycle CPU reset hold and one with a 1-cycle hold.
module tb_ram_loader;

  localparam int AW     = 17;
  localparam int HOLD_A = 16;
  localparam int HOLD_B = 1;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;

  logic        cpu_resetn_a, busy_a, done_a, mis_a;
  logic [15:0] wc_a;
  logic        cpu_resetn_b, busy_b, done_b, mis_b;
  logic [15:0] wc_b;

  ram_loader_if #(.ADDR_WIDTH(AW)) bus ();
  ram_loader_if #(.ADDR_WIDTH(AW)) bus1 ();

  ram_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .RESET_HOLD(HOLD_A)) dut (
    .clk(clk), .resetn(resetn), .bus(bus),
    .cpu_resetn(cpu_resetn_a), .busy(busy_a), .done(done_a),
    .misalign_err(mis_a), .word_count(wc_a)
  );

  ram_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .RESET_HOLD(HOLD_B)) dut_short (
    .clk(clk), .resetn(resetn), .bus(bus1),
    .cpu_resetn(cpu_resetn_b), .busy(busy_b), .done(done_b),
    .misalign_err(mis_b), .word_count(wc_b)
  );

  // The short-hold instance mirrors every input of the main instance.
  assign bus1.in_valid    = bus.in_valid;
  assign bus1.in_addr     = bus.in_addr;
  assign bus1.in_data     = bus.in_data;
  assign bus1.in_last     = bus.in_last;
  assign bus1.ext_awready = bus.ext_awready;
  assign bus1.ext_wready  = bus.ext_wready;
  assign bus1.ext_bvalid  = bus.ext_bvalid;

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: expected RAM writes, completed-write count, sticky flag.
  logic [48:0] exp_q[$];
  logic [48:0] got_q[$];
  int          exp_count;
  bit          exp_mis;

  task automatic clear_model();
    exp_q.delete();
    got_q.delete();
    exp_count = 0;
    exp_mis   = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.in_valid    = 1'b0;
    bus.in_addr     = '0;
    bus.in_data     = '0;
    bus.in_last     = 1'b0;
    bus.ext_awready = 1'b0;
    bus.ext_wready  = 1'b0;
    bus.ext_bvalid  = 1'b0;
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    clear_model();
  endtask

  // Push one load word through capture, AW/W with given ready delays, and B
  // with given response delay. Called and returns on a falling edge.
  task automatic do_word(input logic [16:0] addr, input logic [31:0] data,
                         input logic last, input int aw_dly, input int w_dly,
                         input int b_dly);
    int          n = 0;
    int          cyc = 0;
    int          aw_hi = 0;
    int          w_hi = 0;
    int          exp_cyc;
    bit          aw_seen = 1'b0;
    bit          w_seen = 1'b0;
    bit          valid_err = 1'b0;
    bit          stable_err = 1'b0;
    bit          bready_err = 1'b0;
    logic [16:0] first_addr;
    logic [16:0] got_addr = '0;
    logic [16:0] exp_addr;
    logic [31:0] first_data;
    logic [31:0] got_data = '0;

    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL in_ready_idle: got %b want 1", bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.in_addr  = addr;
    bus.in_data  = data;
    bus.in_last  = last;
    @(negedge clk); cyc++;
    bus.in_valid = 1'b0;
    bus.in_addr  = 17'($urandom);
    bus.in_data  = $urandom;
    bus.in_last  = 1'b0;

    exp_addr = 17'((int'(addr) / 4) * 4);
    exp_q.push_back({exp_addr, data});
    if (int'(addr) % 4 != 0) exp_mis = 1'b1;

    first_addr = bus.ext_awaddr;
    first_data = bus.ext_wdata;
    while (!(aw_seen && w_seen) && n < 50) begin
      if (aw_seen) begin
        if (bus.ext_awvalid !== 1'b0) valid_err = 1'b1;
      end else begin
        aw_hi++;
        if (bus.ext_awvalid !== 1'b1) valid_err = 1'b1;
        if (bus.ext_awaddr !== first_addr) stable_err = 1'b1;
      end
      if (w_seen) begin
        if (bus.ext_wvalid !== 1'b0) valid_err = 1'b1;
      end else begin
        w_hi++;
        if (bus.ext_wvalid !== 1'b1) valid_err = 1'b1;
        if (bus.ext_wdata !== first_data) stable_err = 1'b1;
      end
      bus.ext_awready = !aw_seen && (n >= aw_dly);
      bus.ext_wready  = !w_seen && (n >= w_dly);
      if (bus.ext_awready && bus.ext_awvalid === 1'b1) begin
        aw_seen  = 1'b1;
        got_addr = bus.ext_awaddr;
      end
      if (bus.ext_wready && bus.ext_wvalid === 1'b1) begin
        w_seen   = 1'b1;
        got_data = bus.ext_wdata;
      end
      @(negedge clk); cyc++; n++;
    end
    bus.ext_awready = 1'b0;
    bus.ext_wready  = 1'b0;
    got_q.push_back({got_addr, got_data});

    tests++;
    if (!(aw_seen && w_seen)) begin
      fails++;
      $display("[TB] FAIL write_timeout: aw_seen %b w_seen %b want both 1", aw_seen, w_seen);
    end
    tests++;
    if (valid_err) begin
      fails++;
      $display("[TB] FAIL valid_hold: got valid glitch want held until own handshake");
    end
    tests++;
    if (stable_err) begin
      fails++;
      $display("[TB] FAIL addr_data_stable: got change want stable before accept");
    end
    tests++;
    if (aw_hi != aw_dly + 1 || w_hi != w_dly + 1) begin
      fails++;
      $display("[TB] FAIL valid_cycles: got aw %0d w %0d want aw %0d w %0d",
               aw_hi, w_hi, aw_dly + 1, w_dly + 1);
    end

    for (int k = 0; k < b_dly; k++) begin
      if (bus.ext_bready !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.ext_awvalid !== 1'b0 || bus.ext_wvalid !== 1'b0) bready_err = 1'b1;
      @(negedge clk); cyc++;
    end
    if (bus.ext_bready !== 1'b1 || bus.in_ready !== 1'b0 ||
        bus.ext_awvalid !== 1'b0 || bus.ext_wvalid !== 1'b0) bready_err = 1'b1;
    bus.ext_bvalid = 1'b1;
    @(negedge clk); cyc++;
    bus.ext_bvalid = 1'b0;
    exp_count++;

    tests++;
    if (bready_err) begin
      fails++;
      $display("[TB] FAIL resp_phase: got bready/in_ready/valids wrong want bready 1 in_ready 0 valids 0");
    end
    exp_cyc = 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly;
    tests++;
    if (cyc != exp_cyc) begin
      fails++;
      $display("[TB] FAIL word_cycles: got %0d want %0d", cyc, exp_cyc);
    end
  endtask

  // Compare the RAM writes seen on the bus with the model's expectations.
  task automatic check_writes(input string tag);
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("[TB] FAIL %s_write_count: got %0d want %0d", tag, got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        tests++;
        if (got_q[i] !== exp_q[i]) begin
          fails++;
          $display("[TB] FAIL %s_write%0d: got addr %0h data %0h want addr %0h data %0h",
                   tag, i, got_q[i][48:32], got_q[i][31:0], exp_q[i][48:32], exp_q[i][31:0]);
        end
      end
    end
  endtask

  // Called on the falling edge right after the last word's B handshake:
  // measures how many cycles later each instance releases the CPU.
  task automatic check_run(input string tag);
    int ia = -1;
    int ib = -1;
    tests++;
    if (busy_a !== 1'b1 || cpu_resetn_a !== 1'b0 || done_a !== 1'b0) begin
      fails++;
      $display("[TB] FAIL %s_hold_entry: got busy %b cpu_resetn %b done %b want 1 0 0",
               tag, busy_a, cpu_resetn_a, done_a);
    end
    for (int i = 0; i < 300 && (ia < 0 || ib < 0); i++) begin
      if (ia < 0 && cpu_resetn_a === 1'b1) ia = i;
      if (ib < 0 && cpu_resetn_b === 1'b1) ib = i;
      if (ia < 0 || ib < 0) @(negedge clk);
    end
    tests++;
    if (ia != HOLD_A) begin
      fails++;
      $display("[TB] FAIL %s_hold_long: got %0d want %0d", tag, ia, HOLD_A);
    end
    tests++;
    if (ib != HOLD_B) begin
      fails++;
      $display("[TB] FAIL %s_hold_short: got %0d want %0d", tag, ib, HOLD_B);
    end
    tests++;
    if (done_a !== 1'b1 || busy_a !== 1'b0 || bus.in_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL %s_run_flags: got done %b busy %b in_ready %b want 1 0 0",
               tag, done_a, busy_a, bus.in_ready);
    end
    tests++;
    if (wc_a !== 16'(exp_count)) begin
      fails++;
      $display("[TB] FAIL %s_word_count: got %0d want %0d", tag, wc_a, exp_count);
    end
    tests++;
    if (mis_a !== exp_mis) begin
      fails++;
      $display("[TB] FAIL %s_misalign: got %b want %b", tag, mis_a, exp_mis);
    end
    check_writes(tag);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle_inputs();
    @(negedge clk);
    tests++;
    if ({bus.in_ready, bus.ext_bready, bus.ext_awvalid, bus.ext_wvalid,
         cpu_resetn_a, busy_a, done_a, mis_a} !== 8'b1000_0000) begin
      fails++;
      $display("[TB] FAIL reset_flags: got %b want 10000000",
               {bus.in_ready, bus.ext_bready, bus.ext_awvalid, bus.ext_wvalid,
                cpu_resetn_a, busy_a, done_a, mis_a});
    end
    tests++;
    if (wc_a !== 16'd0 || wc_b !== 16'd0 || cpu_resetn_b !== 1'b0 ||
        busy_b !== 1'b0 || done_b !== 1'b0 || mis_b !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_counts: got wc %0d/%0d want 0/0", wc_a, wc_b);
    end
    resetn = 1'b1;
    clear_model();
    repeat (3) @(negedge clk);
    tests++;
    if (bus.in_ready !== 1'b1 || busy_a !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_idle_hold: got in_ready %b busy %b want 1 0", bus.in_ready, busy_a);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    do_word(17'h0, 32'h11, 1'b0, 0, 0, 0);
    do_word(17'h4, 32'h22, 1'b0, 0, 0, 0);
    do_word(17'h8, 32'h33, 1'b1, 0, 0, 0);
    check_run("basic");
  endtask

  task automatic test_wready_delay();
    apply_reset();
    do_word(17'h40, 32'hCAFE_F00D, 1'b1, 0, 4, 0);
    check_run("wdelay");
  endtask

  task automatic test_misalign();
    apply_reset();
    do_word(17'h1_0006, 32'hA5A5_0001, 1'b1, 1, 0, 1);
    check_run("misalign");
    tests++;
    if (bus.ext_awaddr !== 17'h1_0004) begin
      fails++;
      $display("[TB] FAIL misalign_awaddr: got %0h want 10004", bus.ext_awaddr);
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    do_word(17'h0, 32'h1111_0000, 1'b0, 0, 0, 0);
    bus.in_valid = 1'b1;
    bus.in_addr  = 17'h4;
    bus.in_data  = 32'h2222_0000;
    bus.in_last  = 1'b0;
    @(negedge clk);
    bus.in_valid    = 1'b0;
    bus.ext_awready = 1'b1;
    bus.ext_wready  = 1'b1;
    @(negedge clk);
    bus.ext_awready = 1'b0;
    bus.ext_wready  = 1'b0;
    tests++;
    if (bus.ext_bready !== 1'b1 || busy_a !== 1'b1) begin
      fails++;
      $display("[TB] FAIL midreset_in_resp: got bready %b busy %b want 1 1", bus.ext_bready, busy_a);
    end
    #1 resetn = 1'b0;
    #1;
    tests++;
    if ({bus.ext_awvalid, bus.ext_wvalid, cpu_resetn_a, busy_a, done_a,
         bus.in_ready, bus.ext_bready} !== 7'b0000010) begin
      fails++;
      $display("[TB] FAIL midreset_flags: got %b want 0000010",
               {bus.ext_awvalid, bus.ext_wvalid, cpu_resetn_a, busy_a, done_a,
                bus.in_ready, bus.ext_bready});
    end
    tests++;
    if (wc_a !== 16'd0) begin
      fails++;
      $display("[TB] FAIL midreset_count: got %0d want 0", wc_a);
    end
    @(negedge clk);
    resetn = 1'b1;
    clear_model();
    do_word(17'h8, 32'h3333_0000, 1'b1, 0, 0, 0);
    check_run("midreset");
  endtask

  task automatic test_short_hold();
    bit run_err = 1'b0;
    apply_reset();
    do_word(17'h100, 32'h0BAD_BEEF, 1'b1, 0, 0, 0);
    check_run("shorthold");
    bus.in_valid = 1'b1;
    bus.in_addr  = 17'h200;
    bus.in_data  = 32'h1234_5678;
    bus.in_last  = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus.in_ready !== 1'b0 || bus1.in_ready !== 1'b0 ||
          bus.ext_awvalid !== 1'b0 || bus1.ext_awvalid !== 1'b0) run_err = 1'b1;
    end
    bus.in_valid = 1'b0;
    tests++;
    if (run_err) begin
      fails++;
      $display("[TB] FAIL run_ignores_input: got accept in RUN want in_ready 0 and no write");
    end
    tests++;
    if (wc_a !== 16'd1 || wc_b !== 16'd1 || done_b !== 1'b1 || cpu_resetn_b !== 1'b1) begin
      fails++;
      $display("[TB] FAIL run_terminal: got wc %0d/%0d done_b %b want 1/1 1", wc_a, wc_b, done_b);
    end
  endtask

  task automatic test_bvalid_delay();
    apply_reset();
    do_word(17'h10, 32'hDEAD_0010, 1'b1, 0, 0, 10);
    check_run("bdelay");
  endtask

  task automatic test_random();
    logic [16:0] addr;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      addr = 17'($urandom_range(0, 32'h1FFFF));
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      do_word(addr, $urandom, (i == 7), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    check_run("random");
  endtask

  initial begin
    clear_model();
    idle_inputs();
    test_reset();
    test_basic();
    test_wready_delay();
    test_misalign();
    test_mid_reset();
    test_short_hold();
    test_bvalid_delay();
    test_random();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Last-resort bound on total run time.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 17, SHALL set the byte-address width of the RAM write port.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the write-data width; only 32 is supported.
REQ-003 Parameter RESET_HOLD, default 16, SHALL set the number of cycles (1..255) the CPU is held in reset after the last word is written.
REQ-004 clk  input  1  SHALL be the single clock; all logic is rising-edge.
REQ-005 resetn  input  1  SHALL be the reset: asynchronous, active-low.
REQ-006 in_valid / in_ready  input / output  1 / 1  SHALL form the load-word stream handshake.
REQ-007 in_addr  input  ADDR_WIDTH  SHALL carry the byte address of the load word.
REQ-008 in_data  input  32  SHALL carry the load word.
REQ-009 in_last  input  1  SHALL mark the final word of the image.
REQ-010 ext_awaddr, ext_awvalid / ext_awready  output, output / input  ADDR_WIDTH, 1 / 1  SHALL be the RAM write-address channel.
REQ-011 ext_wdata, ext_wvalid / ext_wready  output, output / input  32, 1 / 1  SHALL be the RAM write-data channel.
REQ-012 ext_bvalid / ext_bready  input / output  1 / 1  SHALL be the RAM write-response channel.
REQ-013 cpu_resetn  output  1  SHALL be the active-low reset driven to the CPU.
REQ-014 busy, done, misalign_err  output  1 each  SHALL be status flags.
REQ-015 word_count  output  16  SHALL report the number of completed RAM writes.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, WRITE, RESP, HOLD and RUN.
REQ-017 In IDLE, in_ready SHALL be 1; all other states SHALL drive in_ready 0.
REQ-018 On an in_valid && in_ready cycle, the block SHALL register addr, data and last, and enter WRITE on the next cycle.
REQ-019 In WRITE, ext_awvalid and ext_wvalid SHALL both be asserted from the first WRITE cycle.
- Each valid SHALL drop independently on its own handshake.
- Address and data SHALL be held stable until accepted.
- The two handshakes SHALL be accepted in either order or in the same cycle.
REQ-020 When both AW and W have completed, the FSM SHALL enter RESP with ext_bready 1; ext_bready SHALL be 0 in all other states.
REQ-021 On ext_bvalid in RESP:
- word_count SHALL increment, saturating at 16'hFFFF.
- The FSM SHALL go to HOLD if the registered last bit is set, otherwise to IDLE.
REQ-022 ext_awaddr SHALL equal the registered address with bits [1:0] forced to 0.
REQ-023 If in_addr[1:0] is nonzero at capture, misalign_err SHALL set sticky and the aligned write SHALL still be performed.
REQ-024 On entering HOLD, an 8-bit counter SHALL load RESET_HOLD-1 and decrement each cycle; at 0 the FSM SHALL enter RUN on the next edge.
- Consequence: cpu_resetn rises exactly RESET_HOLD cycles after the HOLD entry edge.
REQ-025 cpu_resetn SHALL be 1 only in RUN.
REQ-026 done SHALL be 1 only in RUN.
REQ-027 busy SHALL be 1 in WRITE, RESP and HOLD.
REQ-028 RUN SHALL be terminal until resetn is asserted; in_valid SHALL be ignored in RUN.
REQ-029 All outputs SHALL be registered, except in_ready and ext_bready, which SHALL be decoded from state.
REQ-030 Minimum per-word throughput with zero-wait RAM SHALL be 3 cycles:
- capture;
- WRITE with AW and W accepted;
- RESP with B accepted.

Reset
REQ-031 While resetn is 0, the state SHALL be IDLE.
- Reset values: cpu_resetn 0, ext_awvalid 0, ext_wvalid 0, busy 0, done 0, misalign_err 0, word_count 0, hold counter 0.
- Resulting outputs: in_ready 1, ext_bready 0.
REQ-032 A reset asserted mid-transaction SHALL abandon the in-flight write with no completion and SHALL drop all valids immediately.
- Any RAM-side partial handshake is the system's responsibility.
REQ-033 Reset release SHALL be honoured synchronously: the first active edge after resetn rises is the first functional cycle.

Verification
REQ-034 Scenario: three words {0x0,0x11}, {0x4,0x22}, {0x8,0x33, last} with zero-wait RAM -> 3 AXI writes in order, word_count 3, cpu_resetn rises 16 cycles after HOLD entry, done 1.
REQ-035 Scenario: ext_wready delayed 4 cycles while ext_awready is immediate -> awvalid drops after 1 cycle, wvalid held with wdata stable for 5 cycles, single B accepted.
REQ-036 Scenario: in_addr 0x1_0006 -> ext_awaddr 0x1_0004, misalign_err 1 and sticky through RUN.
REQ-037 Scenario: resetn pulsed low during RESP of word 2 -> all valids 0, word_count 0, cpu_resetn 0; reload of 1 word (last) completes normally.
REQ-038 Scenario: RESET_HOLD=1 with a single last word -> cpu_resetn rises on the edge after HOLD entry; in_valid asserted in RUN is never accepted (in_ready 0).
REQ-039 Scenario: ext_bvalid delayed 10 cycles -> ext_bready held 1 throughout, in_ready 0 until the B handshake.
